// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text buffer controller.
package text_pkg;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CURSOR   = 8'h5F;

  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CLEAR  = 2'd2
  } state_e;

endpackage

// File: rtl/blink_timer.sv
// Free-running cursor blink phase generator; phase toggles every BLINK_CYCLES clocks.
module blink_timer #(
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  output logic phase
);

  localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/text_buffer_ctrl.sv
// Character store and write sequencer for the VGA text generator.
// Optional cursor blink overlay enabled by defining CURSOR_BLINK_EN.
module text_buffer_ctrl
  import text_pkg::*;
#(
  parameter int unsigned COLUMNS      = 16,
  parameter int unsigned ROWS         = 4,
  parameter int unsigned BLINK_CYCLES = 25000000,
  localparam int unsigned COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      char_valid,
  input  logic [7:0]                char_in,
  output logic                      char_ready,
  output logic [COLUMNS*ROWS*8-1:0] text_buffer,
  output logic [COL_W-1:0]          cursor_col,
  output logic [ROW_W-1:0]          cursor_row,
  output logic                      busy
);

  localparam int unsigned ROW_BITS = COLUMNS * 8;
  localparam int unsigned BUF_W    = ROWS * ROW_BITS;
  localparam logic [COL_W-1:0]    COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] BLANK_ROW = {COLUMNS{CH_SPACE}};
  localparam logic [BUF_W-1:0]    BLANK_BUF = {(COLUMNS*ROWS){CH_SPACE}};

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] idx_q, idx_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  int unsigned cur_cell;
  logic        accept;
  logic        printable;

  assign cur_cell  = 32'(row_q) * COLUMNS + 32'(col_q);
  assign accept    = char_valid && (state_q == IDLE);
  assign printable = (char_in >= CH_PRINT_LO) && (char_in <= CH_PRINT_HI);

  // Command decode in IDLE, one row per cycle in SCROLL/CLEAR.
  always_comb begin
    int unsigned row_base;
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    row_base = 32'(idx_q) * ROW_BITS;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            buf_d[cur_cell*8 +: 8] = char_in;
            if (col_q != COL_LAST) begin
              col_d = col_q + COL_W'(1);
            end else begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                state_d = SCROLL;
                idx_d   = '0;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end
          end else begin
            case (char_in)
              CH_LF: begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                  state_d = SCROLL;
                  idx_d   = '0;
                end else begin
                  row_d = row_q + ROW_W'(1);
                end
              end
              CH_CR: col_d = '0;
              // Both backspace cases erase the linearly preceding cell.
              CH_BS: begin
                if (col_q != '0) begin
                  col_d = col_q - COL_W'(1);
                  buf_d[(cur_cell-1)*8 +: 8] = CH_SPACE;
                end else if (row_q != '0) begin
                  col_d = COL_LAST;
                  row_d = row_q - ROW_W'(1);
                  buf_d[(cur_cell-1)*8 +: 8] = CH_SPACE;
                end
              end
              CH_FF: begin
                col_d   = '0;
                row_d   = '0;
                idx_d   = '0;
                state_d = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      SCROLL: begin
        if (idx_q != ROW_LAST) begin
          buf_d[row_base +: ROW_BITS] = buf_q[row_base+ROW_BITS +: ROW_BITS];
          idx_d = idx_q + ROW_W'(1);
        end else begin
          buf_d[row_base +: ROW_BITS] = BLANK_ROW;
          state_d = IDLE;
        end
      end

      CLEAR: begin
        buf_d[row_base +: ROW_BITS] = BLANK_ROW;
        if (idx_q == ROW_LAST) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + ROW_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      buf_q   <= BLANK_BUF;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

`ifdef CURSOR_BLINK_EN
  logic blink_phase;

  blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .phase (blink_phase)
  );

  // Output-only overlay; the stored cell is untouched.
  always_comb begin
    text_buffer = buf_q;
    if (blink_phase && (state_q == IDLE)) begin
      text_buffer[cur_cell*8 +: 8] = CH_CURSOR;
    end
  end
`else
  assign text_buffer = buf_q;
`endif

endmodule
